// File: rtl/afifo_pkg.sv
// Shared afifo definitions: entry layout and the read-side drain state encoding.
package afifo_pkg;

  localparam int unsigned DWDTH = 9;
  localparam int unsigned NBITS = 8;
  localparam int unsigned ENBIT = DWDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } rd_state_e;

endpackage

// File: rtl/afifo_skid2.sv
// Two-entry valid/ready skid buffer with synchronous clear; head entry drives data_o.
module afifo_skid2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic [1:0]       occ_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic [1:0]       occ_d, occ_q;
  logic [Width-1:0] data0_d, data0_q;
  logic [Width-1:0] data1_d, data1_q;
  logic             pop;

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = data0_q;
  assign occ_o   = occ_q;
  assign pop     = valid_o && ready_i;

  // Callers never push into a full buffer without a same-edge pop.
  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (clear_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            data0_d = push_data_i;
          end else begin
            data1_d = push_data_i;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          data0_d = data1_q;
          occ_d   = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            data0_d = data1_q;
            data1_d = push_data_i;
          end else begin
            data0_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

endmodule

// File: rtl/afifo_rd_drain.sv
// afifo read-side consumer: pops entries, drops disabled ones, streams payloads,
// with flush sequencing, pop/drop counters and a sticky underflow flag.
module afifo_rd_drain #(
  parameter int unsigned DWDTH = 9,
  parameter int unsigned NBITS = 8,
  parameter int unsigned CWDTH = 8
) (
  input  logic             rclk_i,
  input  logic             rrst_i,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_undrflw_i,
  input  logic [DWDTH-1:0] rdata_i,
  output logic             rinc_o,
  output logic             m_valid_o,
  output logic [NBITS-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             flush_done_o,
  output logic [CWDTH-1:0] drop_cnt_o,
  output logic [CWDTH-1:0] pop_cnt_o,
  output logic             undrflw_sticky_o
);

  import afifo_pkg::*;

  localparam int unsigned EnBit = DWDTH - 1;
  localparam logic [CWDTH-1:0] CntMax = '1;

  if (NBITS != DWDTH - 1) begin : g_width_check
    $error("afifo_rd_drain: NBITS must equal DWDTH-1");
  end

  rd_state_e        state_d, state_q;
  logic [1:0]       occ;
  logic             drain_pop;
  logic             push;
  logic             drop_inc;
  logic [CWDTH-1:0] drop_cnt_d, drop_cnt_q;
  logic [CWDTH-1:0] pop_cnt_d, pop_cnt_q;
  logic             undrflw_d, undrflw_q;

  // Pop decision uses registered occupancy only, so m_ready_i never reaches rinc_o.
  assign rinc_o = !rrst_i && !fifo_empty_i &&
                  ((state_q == FLUSH) || ((state_q == DRAIN) && (occ < 2'd2)));

  assign drain_pop = rinc_o && (state_q == DRAIN);
  assign push      = drain_pop && rdata_i[EnBit] && !flush_i;
  assign drop_inc  = drain_pop && !rdata_i[EnBit];

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:  if (enable_i) state_d = DRAIN;
        DRAIN: if (!enable_i) state_d = IDLE;
        FLUSH: if (fifo_empty_i) state_d = DONE;
        DONE:  state_d = enable_i ? DRAIN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pop_cnt_d  = pop_cnt_q;
    drop_cnt_d = drop_cnt_q;
    undrflw_d  = undrflw_q;
    if (rinc_o) begin
      pop_cnt_d = pop_cnt_q + 1'b1;
    end
    if (drop_inc && (drop_cnt_q != CntMax)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (fifo_undrflw_i || (rinc_o && fifo_empty_i)) begin
      undrflw_d = 1'b1;
    end
  end

  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      state_q    <= IDLE;
      pop_cnt_q  <= '0;
      drop_cnt_q <= '0;
      undrflw_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_cnt_q  <= pop_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      undrflw_q  <= undrflw_d;
    end
  end

  afifo_skid2 #(
    .Width (NBITS)
  ) u_skid (
    .clk_i       (rclk_i),
    .rst_i       (rrst_i),
    .clear_i     (flush_i),
    .push_i      (push),
    .push_data_i (rdata_i[NBITS-1:0]),
    .occ_o       (occ),
    .valid_o     (m_valid_o),
    .ready_i     (m_ready_i),
    .data_o      (m_data_o)
  );

  assign flush_done_o     = (state_q == DONE);
  assign drop_cnt_o       = drop_cnt_q;
  assign pop_cnt_o        = pop_cnt_q;
  assign undrflw_sticky_o = undrflw_q;

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Directed bench for afifo_rd_drain with a behavioural FWFT afifo read-port model.
module tb_afifo_rd_drain;

  localparam int unsigned DWDTH = 9;
  localparam int unsigned NBITS = 8;
  localparam int unsigned CWDTH = 8;

  logic             rclk_i = 1'b0;
  logic             rrst_i;
  logic             enable_i;
  logic             flush_i;
  logic             fifo_empty_i;
  logic             fifo_undrflw_i;
  logic [DWDTH-1:0] rdata_i;
  logic             rinc_o;
  logic             m_valid_o;
  logic [NBITS-1:0] m_data_o;
  logic             m_ready_i;
  logic             flush_done_o;
  logic [CWDTH-1:0] drop_cnt_o;
  logic [CWDTH-1:0] pop_cnt_o;
  logic             undrflw_sticky_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pops = 0;
  int n_done = 0;

  logic [DWDTH-1:0] fq[$];
  logic [NBITS-1:0] got[$];

  afifo_rd_drain #(
    .DWDTH (DWDTH),
    .NBITS (NBITS),
    .CWDTH (CWDTH)
  ) dut (
    .rclk_i           (rclk_i),
    .rrst_i           (rrst_i),
    .enable_i         (enable_i),
    .flush_i          (flush_i),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_undrflw_i   (fifo_undrflw_i),
    .rdata_i          (rdata_i),
    .rinc_o           (rinc_o),
    .m_valid_o        (m_valid_o),
    .m_data_o         (m_data_o),
    .m_ready_i        (m_ready_i),
    .flush_done_o     (flush_done_o),
    .drop_cnt_o       (drop_cnt_o),
    .pop_cnt_o        (pop_cnt_o),
    .undrflw_sticky_o (undrflw_sticky_o)
  );

  always #5 rclk_i = ~rclk_i;

  function automatic void refresh();
    fifo_empty_i = (fq.size() == 0);
    rdata_i      = fifo_empty_i ? '0 : fq[0];
  endfunction

  // afifo model: head advances shortly after a popping edge.
  always @(posedge rclk_i) begin
    if (rinc_o) begin
      n_pops++;
      #1;
      if (fq.size() != 0) fq.delete(0);
      refresh();
    end
  end

  always @(posedge rclk_i) begin
    if (!rrst_i && m_valid_o && m_ready_i) got.push_back(m_data_o);
    if (flush_done_o) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (idx < got.size()) ? 32'(got[idx]) : 32'hDEAD;
    chk(tag, obs, 32'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rclk_i);
  endtask

  task automatic push(input logic [DWDTH-1:0] v);
    fq.push_back(v);
    refresh();
  endtask

  task automatic do_reset();
    rrst_i = 1'b1;
    fq.delete();
    refresh();
    cyc(2);
    got.delete();
    n_pops = 0;
    n_done = 0;
  endtask

  initial begin
    rrst_i         = 1'b1;
    enable_i       = 1'b0;
    flush_i        = 1'b0;
    fifo_undrflw_i = 1'b0;
    m_ready_i      = 1'b1;
    refresh();
    cyc(3);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_pop", 32'(pop_cnt_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_done", 32'(flush_done_o), 32'd0);
    chk("rst_udf", 32'(undrflw_sticky_o), 32'd0);
    chk("rst_rinc", 32'(rinc_o), 32'd0);

    // 1: all-enabled entries stream in order with one-cycle pop latency
    push(9'h1A5);
    push(9'h13C);
    push(9'h1FF);
    enable_i = 1'b1;
    rrst_i   = 1'b0;
    cyc(2);
    chk("t1_first_valid", 32'(m_valid_o), 32'd1);
    chk("t1_first_data", 32'(m_data_o), 32'hA5);
    chk("t1_first_pop", 32'(pop_cnt_o), 32'd1);
    cyc(6);
    chk("t1_count", 32'(got.size()), 32'd3);
    chk_got("t1_d0", 0, 8'hA5);
    chk_got("t1_d1", 1, 8'h3C);
    chk_got("t1_d2", 2, 8'hFF);
    chk("t1_pop", 32'(pop_cnt_o), 32'd3);
    chk("t1_drop", 32'(drop_cnt_o), 32'd0);

    // 2: disabled entries dropped
    do_reset();
    push(9'h011);
    push(9'h122);
    push(9'h033);
    rrst_i = 1'b0;
    cyc(8);
    chk("t2_count", 32'(got.size()), 32'd1);
    chk_got("t2_d0", 0, 8'h22);
    chk("t2_drop", 32'(drop_cnt_o), 32'd2);
    chk("t2_pop", 32'(pop_cnt_o), 32'd3);

    // 3: backpressure fills skid to 2 and stalls pops
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) push(9'h100 | 9'(i));
    rrst_i = 1'b0;
    cyc(8);
    chk("t3_pops", 32'(n_pops), 32'd2);
    chk("t3_left", 32'(fq.size()), 32'd3);
    chk("t3_valid", 32'(m_valid_o), 32'd1);
    chk("t3_hold0", 32'(m_data_o), 32'h01);
    chk("t3_rinc", 32'(rinc_o), 32'd0);
    cyc(2);
    chk("t3_hold1", 32'(m_data_o), 32'h01);
    m_ready_i = 1'b1;
    cyc(10);
    chk("t3_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_got("t3_order", i, 8'(i + 1));
    chk("t3_pop", 32'(pop_cnt_o), 32'd5);

    // 4: flush with full skid and 4 entries resident
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) push(9'h1A0 | 9'(i));
    rrst_i = 1'b0;
    cyc(6);
    chk("t4_pre_pops", 32'(n_pops), 32'd2);
    chk("t4_pre_left", 32'(fq.size()), 32'd4);
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    chk("t4_valid_cleared", 32'(m_valid_o), 32'd0);
    cyc(8);
    chk("t4_pops", 32'(n_pops), 32'd6);
    chk("t4_done_pulses", 32'(n_done), 32'd1);
    chk("t4_done_now", 32'(flush_done_o), 32'd0);
    chk("t4_drop", 32'(drop_cnt_o), 32'd0);
    chk("t4_pop", 32'(pop_cnt_o), 32'd6);
    chk("t4_valid", 32'(m_valid_o), 32'd0);

    // 5: drop counter saturates, pop counter wraps
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) push(9'(i & 8'hFF));
    rrst_i = 1'b0;
    cyc(262);
    chk("t5_drop_sat", 32'(drop_cnt_o), 32'd255);
    chk("t5_pop_wrap", 32'(pop_cnt_o), 32'd0);
    chk("t5_pops", 32'(n_pops), 32'd256);
    chk("t5_valid", 32'(m_valid_o), 32'd0);

    // 6: reset mid-drain, then sticky underflow
    do_reset();
    m_ready_i = 1'b0;
    push(9'h1B1);
    push(9'h1B2);
    push(9'h1B3);
    rrst_i = 1'b0;
    cyc(2);
    chk("t6_valid_pre", 32'(m_valid_o), 32'd1);
    chk("t6_rinc_pre", 32'(rinc_o), 32'd1);
    rrst_i = 1'b1;
    #1;
    chk("t6_rinc_gated", 32'(rinc_o), 32'd0);
    cyc(1);
    chk("t6_valid_rst", 32'(m_valid_o), 32'd0);
    chk("t6_data_rst", 32'(m_data_o), 32'd0);
    chk("t6_pop_rst", 32'(pop_cnt_o), 32'd0);
    chk("t6_drop_rst", 32'(drop_cnt_o), 32'd0);
    rrst_i         = 1'b0;
    fifo_undrflw_i = 1'b1;
    cyc(1);
    fifo_undrflw_i = 1'b0;
    chk("t6_udf_set", 32'(undrflw_sticky_o), 32'd1);
    cyc(3);
    chk("t6_udf_hold", 32'(undrflw_sticky_o), 32'd1);
    rrst_i = 1'b1;
    cyc(1);
    chk("t6_udf_clr", 32'(undrflw_sticky_o), 32'd0);
    rrst_i = 1'b0;
    cyc(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
